ni_rx_depacketizer: RTL and testbench
=====================================

Name: ni_rx_depacketizer

Overview:
- Receive half of the network interface. It takes two-flit packets (head = address, tail = data) from the router ejection link using a valid/ready handshake.
- It reassembles each packet into an {addr, data} pair and buffers the pair in an internal FIFO.
- The core drains the FIFO through a read-enable port. The port mirrors the NI transmit side's core_write_addr/core_write_data/core_write_en interface.

Parameters:
- DATA_W, 32, width of address and data words; flit width is DATA_W+2
- DEPTH, 8, reassembled-packet FIFO entries; power of 2, >= 2
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flit_in  in  DATA_W+2  [DATA_W+1:DATA_W] type (2'b01 head, 2'b10 tail, others illegal); [DATA_W-1:0] payload
- flit_valid  in  1  flit_in valid
- flit_ready  out  1  depacketizer can accept flit_in
- core_read_en  in  1  pop one packet
- core_read_addr  out  DATA_W  address of last popped packet
- core_read_data  out  DATA_W  data of last popped packet
- core_read_valid  out  1  FIFO non-empty
- fifo_count  out  PTR_W+1  entries held, 0..DEPTH
- proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (reset=0, async): state=IDLE; FIFO pointers=0; fifo_count=0; core_read_addr=0; core_read_data=0; proto_err=0; addr_hold=0. Outputs derived from these: core_read_valid=0, flit_ready=1.
- Flit accept: a flit is taken on a rising edge where flit_valid & flit_ready.
- flit_ready is combinational: 0 only when state=WAIT_TAIL and fifo_count==DEPTH; otherwise 1. A pop in the same cycle does not raise flit_ready (no bypass).
- FSM states: IDLE, WAIT_TAIL.
  - IDLE, head accepted: addr_hold<=payload; go to WAIT_TAIL.
  - IDLE, tail accepted: flit dropped; proto_err=1 next cycle; stay IDLE.
  - WAIT_TAIL, tail accepted: write {addr_hold, payload} at wr_ptr; wr_ptr++; go to IDLE.
  - WAIT_TAIL, head accepted: addr_hold overwritten; proto_err pulse; stay WAIT_TAIL. The earlier head is discarded.
  - Any state, illegal type (00/11) accepted: dropped; proto_err pulse; state unchanged.
- proto_err is registered: high exactly one cycle after the offending accept edge.
- Pop: on a rising edge with core_read_en=1 and fifo_count>0:
  - core_read_addr/core_read_data <= entry at rd_ptr
  - rd_ptr++
  - Popped data is visible the cycle after the enable: 1-cycle latency.
- core_read_en with fifo_count==0: ignored; outputs hold; no error.
- core_read_addr/data hold their value between pops.
- Pointers are PTR_W bits and wrap modulo DEPTH. fifo_count is kept explicitly: +1 on write, −1 on pop, unchanged when both occur in the same cycle.
- core_read_valid = (fifo_count!=0), combinational from the register.
- A tail write and a pop in the same cycle at fifo_count==0: the pop is ignored and the write lands; fifo_count becomes 1.
- Reset asserted mid-packet discards addr_hold and all buffered entries immediately. After release, a tail flit with no head is a protocol error.

Test Plan:
- Reset, then head A5A5A5A5 followed by tail AAAAAAAA; pulse core_read_en -> one cycle after the pop, core_read_addr=A5A5A5A5 and core_read_data=AAAAAAAA; fifo_count goes 0→1→0; core_read_valid 1 only while count=1.
- Send DEPTH=8 packets (addr=i, data=100+i) without popping, then a head for a 9th packet -> head accepted; flit_ready=0 in WAIT_TAIL; tail held off until one pop, then accepted. Pops return addr 0..8 in order, which exercises pointer wrap.
- Tail 12345678 in IDLE -> no FIFO write, fifo_count stays 0, proto_err high exactly one cycle. Then head 1, head 2, tail 3 -> one proto_err pulse; single entry {2,3}.
- core_read_en held high with an empty FIFO -> core_read_addr/data unchanged (0 after reset); fifo_count stays 0. Same-cycle tail write + pop at count 0 -> count=1, outputs unchanged.
- With count=3 and an accepted tail coinciding with a pop -> count stays 3; popped entry is the oldest.
- Assert reset (low) asynchronously between head and tail with 2 entries buffered -> immediately fifo_count=0, core_read_valid=0, flit_ready=1. A tail after release gives proto_err and no write.

Source files
------------

// File: rtl/ni_rx_depacketizer.sv
// Receive-side network interface: reassembles head/tail flit pairs into
// {addr, data} entries, buffers them in a FIFO, and lets the core pop them.
module ni_rx_depacketizer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W+1:0] flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic              core_read_en,
  output logic [DATA_W-1:0] core_read_addr,
  output logic [DATA_W-1:0] core_read_data,
  output logic              core_read_valid,
  output logic [PTR_W:0]    fifo_count,
  output logic              proto_err
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_TAIL = 1'b1;

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_hold_q, addr_hold_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              proto_err_q, proto_err_d;

  logic [DATA_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [1:0]        flit_type;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              is_head;
  logic              is_tail;
  logic              wr_en;
  logic              pop_en;

  assign flit_type = flit_in[DATA_W+1:DATA_W];
  assign payload   = flit_in[DATA_W-1:0];

  // Back-pressure only when a tail would have nowhere to land; a same-cycle
  // pop deliberately does not bypass into the ready path.
  assign flit_ready = !((state_q == ST_WAIT_TAIL) && (count_q == FULL_COUNT));

  assign accept  = flit_valid && flit_ready;
  assign is_head = (flit_type == TYPE_HEAD);
  assign is_tail = (flit_type == TYPE_TAIL);
  assign wr_en   = accept && is_tail && (state_q == ST_WAIT_TAIL);
  assign pop_en  = core_read_en && (count_q != '0);

  always_comb begin
    state_d     = state_q;
    addr_hold_d = addr_hold_q;
    proto_err_d = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (is_head) begin
            addr_hold_d = payload;
            state_d     = ST_WAIT_TAIL;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        ST_WAIT_TAIL: begin
          if (is_tail) begin
            state_d = ST_IDLE;
          end else if (is_head) begin
            addr_hold_d = payload;
            proto_err_d = 1'b1;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_addr_d = mem_addr[rd_ptr_q];
      rd_data_d = mem_data[rd_ptr_q];
    end
    case ({wr_en, pop_en})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_hold_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_hold_q <= addr_hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_addr[wr_ptr_q] <= addr_hold_q;
      mem_data[wr_ptr_q] <= payload;
    end
  end

  assign core_read_addr  = rd_addr_q;
  assign core_read_data  = rd_data_q;
  assign core_read_valid = (count_q != '0);
  assign fifo_count      = count_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_ni_rx_depacketizer.sv
// Scoreboard bench for ni_rx_depacketizer: a queue-based packet model predicts
// pops and status; a separate monitor checks the core read port every cycle.
module tb_ni_rx_depacketizer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  localparam logic [1:0] TH = 2'b01;
  localparam logic [1:0] TT = 2'b10;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW+1:0]   flit_in;
  logic            flit_valid;
  logic            flit_ready;
  logic            core_read_en;
  logic [DW-1:0]   core_read_addr;
  logic [DW-1:0]   core_read_data;
  logic            core_read_valid;
  logic [PTR_W:0]  fifo_count;
  logic            proto_err;

  ni_rx_depacketizer #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .flit_in        (flit_in),
    .flit_valid     (flit_valid),
    .flit_ready     (flit_ready),
    .core_read_en   (core_read_en),
    .core_read_addr (core_read_addr),
    .core_read_data (core_read_data),
    .core_read_valid(core_read_valid),
    .fifo_count     (fifo_count),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: buffered packets, pending-head state, last error flag.
  logic [2*DW-1:0] mq[$];
  logic [2*DW-1:0] exp_q[$];
  bit              m_wait = 1'b0;
  logic [DW-1:0]   m_hold = '0;
  bit              m_err  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_ready();
    return !(m_wait && (mq.size() == DEPTH));
  endfunction

  // Apply one cycle of stimulus, advance the model across the edge, check status.
  task automatic cycle(input bit fv, input logic [1:0] ty, input logic [DW-1:0] pl, input bit en);
    bit acc;
    bit err;
    flit_valid   = fv;
    flit_in      = {ty, pl};
    core_read_en = en;
    acc = fv && m_ready();
    err = 1'b0;
    if (en && mq.size() > 0) exp_q.push_back(mq.pop_front());
    if (acc) begin
      if (ty == TH) begin
        err    = m_wait;
        m_hold = pl;
        m_wait = 1'b1;
      end else if (ty == TT) begin
        if (m_wait) begin
          mq.push_back({m_hold, pl});
          m_wait = 1'b0;
        end else begin
          err = 1'b1;
        end
      end else begin
        err = 1'b1;
      end
    end
    m_err = err;
    @(posedge clk);
    #1;
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
    check("core_read_valid", 64'(core_read_valid), 64'(mq.size() != 0));
    check("flit_ready", 64'(flit_ready), 64'(m_ready()));
    check("proto_err", 64'(proto_err), 64'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, 1'b0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, 1'b1);
  endtask

  task automatic packet(input logic [DW-1:0] a, input logic [DW-1:0] d);
    cycle(1'b1, TH, a, 1'b0);
    cycle(1'b1, TT, d, 1'b0);
  endtask

  // Asynchronous reset placed mid-cycle, away from both clock edges.
  task automatic do_reset();
    flit_valid   = 1'b0;
    core_read_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_read_valid", 64'(core_read_valid), 64'd0);
    check("rst_flit_ready", 64'(flit_ready), 64'd1);
    mq.delete();
    m_wait = 1'b0;
    m_hold = '0;
    m_err  = 1'b0;
    @(negedge clk);
    #1;
    check("rst_proto_err", 64'(proto_err), 64'd0);
    #1 reset = 1'b1;
  endtask

  // Monitor: a pop seen before an edge retires one scoreboard entry after it;
  // otherwise the read port must hold its last value.
  initial begin
    bit            pend = 1'b0;
    logic [DW-1:0] la   = '0;
    logic [DW-1:0] ld   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
        la   = '0;
        ld   = '0;
      end else if (pend) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected: got pop expected none at %0t", $time);
        end else begin
          {la, ld} = exp_q.pop_front();
        end
      end
      check("core_read_addr", 64'(core_read_addr), 64'(la));
      check("core_read_data", 64'(core_read_data), 64'(ld));
      pend = reset && core_read_en && core_read_valid;
    end
  end

  initial begin
    logic [1:0] ty;
    int         r;
    reset        = 1'b0;
    flit_valid   = 1'b0;
    flit_in      = '0;
    core_read_en = 1'b0;
    #1;
    check("init_fifo_count", 64'(fifo_count), 64'd0);
    check("init_read_valid", 64'(core_read_valid), 64'd0);
    check("init_flit_ready", 64'(flit_ready), 64'd1);
    check("init_proto_err", 64'(proto_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    // Single packet round trip.
    packet(32'hA5A5A5A5, 32'hAAAAAAAA);
    pops(1);
    idle(2);

    // Fill to DEPTH, then a 9th head; its tail is held off until a pop.
    for (int i = 0; i < DEPTH; i++) packet(DW'(i), DW'(100 + i));
    cycle(1'b1, TH, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, TT, 32'd108, 1'b0);
    cycle(1'b1, TT, 32'd108, 1'b1);
    cycle(1'b1, TT, 32'd108, 1'b0);
    idle(1);
    pops(DEPTH + 2);

    // Protocol violations.
    cycle(1'b1, TT, 32'h12345678, 1'b0);
    idle(1);
    cycle(1'b1, TH, 32'd1, 1'b0);
    cycle(1'b1, TH, 32'd2, 1'b0);
    cycle(1'b1, TT, 32'd3, 1'b0);
    idle(1);
    pops(1);
    cycle(1'b1, 2'b00, 32'hDEAD0000, 1'b0);
    cycle(1'b1, TH, 32'h77, 1'b0);
    cycle(1'b1, 2'b11, 32'hDEAD0011, 1'b0);
    cycle(1'b1, TT, 32'h88, 1'b0);
    pops(1);

    // Pops against an empty FIFO, then a tail write racing a pop at count 0.
    pops(3);
    cycle(1'b1, TH, 32'h55, 1'b0);
    cycle(1'b1, TT, 32'h66, 1'b1);
    idle(1);
    pops(2);

    // Write and pop together at count 3.
    for (int i = 0; i < 3; i++) packet(DW'(32'h200 + i), DW'(32'h300 + i));
    cycle(1'b1, TH, 32'h203, 1'b0);
    cycle(1'b1, TT, 32'h303, 1'b1);
    pops(5);

    // Reset between head and tail with two entries buffered.
    packet(32'h400, 32'h500);
    packet(32'h401, 32'h501);
    cycle(1'b1, TH, 32'h402, 1'b0);
    do_reset();
    cycle(1'b1, TT, 32'h502, 1'b0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      ty = (r < 4) ? TH : (r < 8) ? TT : (r == 8) ? 2'b00 : 2'b11;
      cycle($urandom_range(0, 9) < 7, ty, $urandom, $urandom_range(0, 9) < 3);
    end
    pops(DEPTH + 1);
    idle(3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
